spi_flash_stream: RTL and testbench

//  Parametrised SPI flash reader; successor to the fixed-size ROM loader.

---
 rtl/spi_flash_stream.sv | 187 ++++++++++++++++++
 tb/tb_spi_flash_stream.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_stream.sv
// spi_flash_stream: wakes an SPI flash from deep power-down, then streams READ (0x03) bursts as DATA_WIDTH words
//   clk, reset               system clock, synchronous active-high reset
//   start/start_addr/word_count  request, accepted only while ready
//   ready, busy, done        idle-and-awake, transfer in progress, end-of-request pulse
//   data/valid/out_ready     single-stage output stream
//   spi_cs/spi_sclk/spi_mosi/spi_miso  mode-0 flash pins
module spi_flash_stream #(
  parameter int DATA_WIDTH  = 16,
  parameter int CLK_DIV     = 1,
  parameter int WAKE_CYCLES = 48,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [23:0]           start_addr,
  input  logic [15:0]           word_count,
  output logic                  ready,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  spi_cs,
  output logic                  spi_sclk,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  typedef enum logic [2:0] {WAKE_CMD, WAKE_WAIT, IDLE, CMD, DATA, STALL, CS_GAP} state_t;
  localparam int DVW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DVW-1:0] DIV_END = DVW'(CLK_DIV - 1);
  localparam logic [7:0] DAT_END = 8'(DATA_WIDTH - 1);
  localparam logic [15:0] WAKE_END = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] GAP_END = 16'(CS_HIGH_MIN - 1);
  state_t state_q, state_d;
  logic cs_q, cs_d, sclk_q, sclk_d, valid_q, valid_d, zdone_q, zdone_d;
  logic [DVW-1:0] div_q, div_d;
  logic [7:0] bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d, pend_q, pend_d, rem_q, rem_d;
  logic [31:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d, data_q, data_d, rx_next;
  logic tick, run, rise, fall, accept;
  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    div_d   = div_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    data_d  = data_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    rem_d   = rem_q;
    zdone_d = 1'b0;
    tick    = div_q == DIV_END;
    // SCLK only runs while CS is low; in DATA it stops once no words remain to shift,
    // and in STALL it is allowed to finish its high phase so it parks low
    run     = !cs_q && (state_q == WAKE_CMD || state_q == CMD ||
              (state_q == DATA && (pend_q != 16'd0 || sclk_q)) || (state_q == STALL && sclk_q));
    rise    = run && tick && !sclk_q;
    fall    = run && tick && sclk_q;
    accept  = valid_q && out_ready;
    rx_next = {rx_q[DATA_WIDTH-2:0], spi_miso};
    if (run) begin
      div_d  = tick ? '0 : div_q + 1'b1;
      sclk_d = sclk_q ^ tick;
    end
    if (fall) tx_d = {tx_q[30:0], 1'b0};
    if (accept) begin
      valid_d = 1'b0;
      rem_d   = rem_q - 16'd1;
    end
    case (state_q)
      WAKE_CMD: begin
        if (cs_q) cs_d = 1'b0;
        else if (fall) begin
          bit_d = bit_q + 8'd1;
          if (bit_q == 8'd7) begin
            bit_d   = '0;
            cs_d    = 1'b1;
            cnt_d   = '0;
            state_d = WAKE_WAIT;
          end
        end
      end
      WAKE_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == WAKE_END) state_d = IDLE;
      end
      IDLE: begin
        if (start && word_count != 16'd0) begin
          tx_d    = {8'h03, start_addr};
          pend_d  = word_count;
          rem_d   = word_count;
          cs_d    = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = CMD;
        end else if (start) zdone_d = 1'b1;
      end
      CMD: begin
        if (fall) begin
          bit_d = bit_q + 8'd1;
          if (bit_q == 8'd31) begin
            bit_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (rise) begin
          rx_d  = rx_next;
          bit_d = bit_q + 8'd1;
          if (bit_q == DAT_END) begin
            bit_d  = '0;
            pend_d = pend_q - 16'd1;
            if (!valid_q || out_ready) begin
              data_d  = rx_next;
              valid_d = 1'b1;
            end else state_d = STALL;
          end
        end
        if (accept && rem_q == 16'd1) begin
          state_d = CS_GAP;
          cs_d    = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
        end
      end
      STALL: begin
        // completed word waits in rx_q; it moves out as soon as the register frees
        if (accept) begin
          data_d  = rx_q;
          valid_d = 1'b1;
          state_d = DATA;
        end
      end
      CS_GAP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == GAP_END) state_d = IDLE;
      end
      default: state_d = WAKE_CMD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAKE_CMD;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      div_q   <= '0;
      bit_q   <= '0;
      cnt_q   <= '0;
      tx_q    <= {8'hAB, 24'h0};
      rx_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      rem_q   <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      pend_q  <= pend_d;
      rem_q   <= rem_d;
      zdone_q <= zdone_d;
    end
  end
  assign ready    = state_q == IDLE;
  assign busy     = state_q == CMD || state_q == DATA || state_q == STALL || state_q == CS_GAP;
  assign done     = zdone_q || (state_q == CS_GAP && cnt_q == GAP_END);
  assign data     = data_q;
  assign valid    = valid_q;
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = tx_q[31] & ~cs_q;
endmodule

// File: tb/tb_spi_flash_stream.sv
// tb_spi_flash_stream: directed checks of spi_flash_stream against a behavioural SPI flash
module tb_spi_flash_stream;
  logic clk = 0, reset = 1;
  logic a_start = 0, a_ordy = 1, a_miso = 0, a_ready, a_busy, a_valid, a_done, a_cs, a_sclk, a_mosi;
  logic [23:0] a_addr = 0;
  logic [15:0] a_wc = 0, a_data;
  logic b_start = 0, b_ordy = 1, b_miso = 0, b_ready, b_busy, b_valid, b_done, b_cs, b_sclk, b_mosi;
  logic [23:0] b_addr = 0;
  logic [15:0] b_wc = 0;
  logic [7:0] b_data;
  int nvec = 0, nmis = 0;
  int a_rises = 0, a_falls = 0, a_dones = 0, b_rises = 0;
  int fa_n = 0, fb_n = 0, la_n = 0, lb_n = 0;
  logic [31:0] fa_cmd = 0, fb_cmd = 0, la_cmd = 0, lb_cmd = 0;
  longint b_last = 0, b_per = 0;
  logic [15:0] wq_a[$];
  logic [7:0] wq_b[$];
  logic [15:0] exp_a[3] = '{16'h1122, 16'h3344, 16'h5566};

  spi_flash_stream dut_a (.clk(clk), .reset(reset), .start(a_start), .start_addr(a_addr), .word_count(a_wc),
    .ready(a_ready), .busy(a_busy), .data(a_data), .valid(a_valid), .out_ready(a_ordy), .done(a_done),
    .spi_cs(a_cs), .spi_sclk(a_sclk), .spi_mosi(a_mosi), .spi_miso(a_miso));
  spi_flash_stream #(.DATA_WIDTH(8), .CLK_DIV(3)) dut_b (.clk(clk), .reset(reset), .start(b_start),
    .start_addr(b_addr), .word_count(b_wc), .ready(b_ready), .busy(b_busy), .data(b_data), .valid(b_valid),
    .out_ready(b_ordy), .done(b_done), .spi_cs(b_cs), .spi_sclk(b_sclk), .spi_mosi(b_mosi), .spi_miso(b_miso));

  always #5 clk = ~clk;

  function automatic logic [7:0] mem(input logic [23:0] a);
    if (a >= 24'h100 && a <= 24'h105) return 8'((a - 24'h0FF) * 24'h11);
    if (a == 24'hFFFFFF) return 8'hA5;
    if (a == 24'h0) return 8'h5A;
    return 8'h00;
  endfunction
  function automatic logic fbit(input logic [23:0] a, input int n);
    logic [7:0] b;
    b = mem(a + 24'(n / 8));
    return b[7 - (n % 8)];
  endfunction

  always @(posedge a_sclk or posedge a_cs)
    if (a_cs) fa_n <= 0;
    else begin
      if (fa_n < 32) fa_cmd <= {fa_cmd[30:0], a_mosi};
      fa_n <= fa_n + 1;
    end
  always @(posedge a_cs) begin la_cmd = fa_cmd; la_n = fa_n; end
  always @(negedge a_sclk) if (!a_cs && fa_n >= 32) a_miso = fbit(fa_cmd[23:0], fa_n - 32);
  always @(posedge a_sclk) a_rises++;
  always @(negedge a_cs) a_falls++;
  always @(posedge clk) if (a_done) a_dones++;
  always @(posedge clk) if (a_valid && a_ordy) wq_a.push_back(a_data);

  always @(posedge b_sclk or posedge b_cs)
    if (b_cs) fb_n <= 0;
    else begin
      if (fb_n < 32) fb_cmd <= {fb_cmd[30:0], b_mosi};
      fb_n <= fb_n + 1;
    end
  always @(posedge b_cs) begin lb_cmd = fb_cmd; lb_n = fb_n; end
  always @(negedge b_sclk) if (!b_cs && fb_n >= 32) b_miso = fbit(fb_cmd[23:0], fb_n - 32);
  always @(posedge b_sclk) begin b_rises++; b_per = $time - b_last; b_last = $time; end
  always @(posedge clk) if (b_valid && b_ordy) wq_b.push_back(b_data);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic start_a(input logic [23:0] addr, input logic [15:0] wc);
    a_addr = addr;
    a_wc = wc;
    a_start = 1;
    tick();
    a_start = 0;
  endtask
  task automatic wait_done_a(input string tag);
    for (int i = 0; i < 1000 && !a_done; i++) tick();
    chk(tag, 32'(a_done), 1);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_cs", 32'(a_cs), 1);
    chk("rst_sclk", 32'(a_sclk), 0);
    chk("rst_mosi", 32'(a_mosi), 0);
    chk("rst_valid", 32'(a_valid), 0);
    chk("rst_ready", 32'(a_ready), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_data", 32'(a_data), 0);
    reset = 0;
    for (int i = 0; i < 300 && !a_ready; i++) tick();
    chk("wake_ready", 32'(a_ready), 1);
    chk("wake_sclk", a_rises, 8);
    chk("wake_cmd", 32'(la_cmd[7:0]), 'hAB);
    chk("wake_bits", la_n, 8);
    chk("wake_csfall", a_falls, 1);
    repeat (5) tick();
    chk("idle_cs", 32'(a_cs), 1);
    chk("idle_ready", 32'(a_ready), 1);

    a_rises = 0; a_falls = 0; a_dones = 0; wq_a.delete();
    start_a(24'h000100, 16'd3);
    chk("t2_busy", 32'(a_busy), 1);
    chk("t2_cs", 32'(a_cs), 0);
    chk("t2_ready", 32'(a_ready), 0);
    wait_done_a("t2_done");
    repeat (3) tick();
    chk("t2_cmd", la_cmd, 'h03000100);
    chk("t2_sclk", a_rises, 80);
    chk("t2_nwords", wq_a.size(), 3);
    for (int i = 0; i < 3; i++) chk("t2_word", 32'(wq_a[i]), 32'(exp_a[i]));
    chk("t2_dones", a_dones, 1);
    chk("t2_csfall", a_falls, 1);
    chk("t2_ready_after", 32'(a_ready), 1);

    a_rises = 0; a_dones = 0; wq_a.delete(); a_ordy = 0;
    start_a(24'h000100, 16'd3);
    for (int i = 0; i < 300 && !a_valid; i++) tick();
    chk("t3_valid", 32'(a_valid), 1);
    repeat (100) tick();
    chk("t3_sclk_rises", a_rises, 64);
    chk("t3_sclk_low", 32'(a_sclk), 0);
    chk("t3_cs_low", 32'(a_cs), 0);
    chk("t3_held_valid", 32'(a_valid), 1);
    chk("t3_held_data", 32'(a_data), 'h1122);
    a_ordy = 1;
    wait_done_a("t3_done");
    repeat (3) tick();
    chk("t3_nwords", wq_a.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_word", 32'(wq_a[i]), 32'(exp_a[i]));
    chk("t3_sclk", a_rises, 80);
    chk("t3_dones", a_dones, 1);

    a_dones = 0; a_falls = 0; wq_a.delete();
    start_a(24'h000100, 16'd0);
    chk("t4_zdone", 32'(a_done), 1);
    chk("t4_zready", 32'(a_ready), 1);
    chk("t4_zcs", 32'(a_cs), 1);
    tick();
    chk("t4_zdone_end", 32'(a_done), 0);
    chk("t4_zcsfall", a_falls, 0);
    start_a(24'h000102, 16'd1);
    repeat (5) tick();
    start_a(24'h000000, 16'd5);
    wait_done_a("t4_done");
    repeat (10) tick();
    chk("t4_nwords", wq_a.size(), 1);
    chk("t4_word", 32'(wq_a[0]), 'h3344);
    chk("t4_cmd", la_cmd, 'h03000102);
    chk("t4_csfall", a_falls, 1);
    chk("t4_dones", a_dones, 2);

    a_rises = 0;
    start_a(24'h000100, 16'd3);
    for (int i = 0; i < 100 && a_rises < 12; i++) tick();
    chk("t5_in_addr", a_rises, 12);
    reset = 1;
    tick();
    chk("t5_cs", 32'(a_cs), 1);
    chk("t5_valid", 32'(a_valid), 0);
    chk("t5_done", 32'(a_done), 0);
    chk("t5_busy", 32'(a_busy), 0);
    tick();
    a_rises = 0; a_dones = 0;
    reset = 0;
    for (int i = 0; i < 300 && !a_ready; i++) tick();
    chk("t5_ready", 32'(a_ready), 1);
    chk("t5_wake_sclk", a_rises, 8);
    chk("t5_wake_cmd", 32'(la_cmd[7:0]), 'hAB);
    chk("t5_wake_bits", la_n, 8);
    chk("t5_no_done", a_dones, 0);

    for (int i = 0; i < 500 && !b_ready; i++) tick();
    chk("t6_ready", 32'(b_ready), 1);
    b_rises = 0; wq_b.delete();
    b_addr = 24'hFFFFFF; b_wc = 16'd2; b_start = 1;
    tick();
    b_start = 0;
    for (int i = 0; i < 2000 && !b_done; i++) tick();
    chk("t6_done", 32'(b_done), 1);
    repeat (5) tick();
    chk("t6_cmd", lb_cmd, 'h03FFFFFF);
    chk("t6_sclk", b_rises, 48);
    chk("t6_period", 32'(b_per), 60);
    chk("t6_nwords", wq_b.size(), 2);
    chk("t6_word0", 32'(wq_b[0]), 'hA5);
    chk("t6_word1", 32'(wq_b[1]), 'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
